imem_loader: RTL
================

Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words little-endian, and issues one write per word into a writable instruction RAM. It holds the CPU in reset (cpu_hold) until the image is loaded, then reports the loaded length so the fetch side returns 0 for addresses at or beyond it.

Parameters:
N, 32, instruction word width; fixed at 32, a multiple of 8.
DEPTH, 64, instruction RAM depth in words; must be ≤255 because the header is 8 bits.
ADDR_W, 6, write address width; clog2(DEPTH), matching the 6-bit fetch address.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset; asserted when 0.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts a byte this cycle.
restart  in  1  single-cycle pulse; aborts the current load or re-arms after DONE/ERR.
wr_en  out  1  instruction RAM write strobe, one cycle per word.
wr_addr  out  ADDR_W  word address of the write.
wr_data  out  N  assembled instruction word.
word_count  out  ADDR_W+1  number of words written so far.
done  out  1  image fully loaded.
err  out  1  header invalid.
cpu_hold  out  1  keep the CPU in reset; 1 until done.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1. in_ready is combinational: 1 in WAIT_HDR and DATA, 0 in DONE and ERR, and forced to 0 in any cycle where restart is 1.
- Reset (reset=0, asynchronous) forces state WAIT_HDR, byte_idx=0, word_idx=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0, done=0, err=0, cpu_hold=1.
- A reset during DATA abandons the load. RAM words already written are not cleared. word_count=0 makes the fetch side read them as 0.
- FSM states:
  - WAIT_HDR: an accepted byte is the header h.
    - h==0 or h>DEPTH: go to ERR.
    - Otherwise latch target=h, clear byte_idx, word_idx and word_count, go to DATA.
  - DATA: each accepted byte is shifted into bits [8*byte_idx+7 : 8*byte_idx] of the assembly register; byte_idx increments mod 4.
    - On the 4th byte (byte_idx==3), the next cycle drives wr_en=1, wr_addr=word_idx and wr_data=the full word. This is a registered write with 1-cycle latency from the last byte's accept edge.
    - word_idx and word_count increment on that same write cycle.
    - When the write of word target-1 occurs, go to DONE on the same edge that launches that write.
  - DONE: done=1, cpu_hold=0, in_ready=0. word_count holds target. All stream input is ignored.
  - ERR: err=1, cpu_hold=1, in_ready=0.
- wr_en is high for exactly one cycle per word and never twice in a row for the same address. wr_data and wr_addr are don't-care when wr_en=0 but hold their last value.
- restart=1 in any state: on the next edge go to WAIT_HDR and clear byte_idx, word_idx, word_count, done and err; set cpu_hold=1.
  - restart has priority over a byte accept (in_ready=0 that cycle).
  - A pending registered write launched on the same edge still completes.
- in_valid gaps of any length between bytes are legal; partial-word state is held.
- Extra bytes after DONE are not consumed (in_ready=0).

Decomposition:
- Package imem_pkg: typedef loader_state_t enum {WAIT_HDR, DATA, DONE, ERR}; constants IMEM_DEPTH=64, IMEM_ADDR_W=6, INSTR_W=32. The fetch module uses the same package.
- One natural sub-module: word_assembler (byte shift register, byte_idx counter, word_ready pulse). The FSM and address counters stay in imem_loader.

Test Plan:
- Basic load: after reset, send 02, 00 00 00 F8, 01 80 00 F8 with in_valid held high. Expect exactly two writes, addr0=F8000000 and addr1=F8008001, each 1 cycle after its 4th byte; then done=1, cpu_hold=0, word_count=2, in_ready=0.
- Bad header: header 00 gives err=1, in_ready=0, no wr_en. restart pulse returns to WAIT_HDR with err=0. Header 41 (65>64) also gives err=1.
- Bubbles: the basic load with in_valid toggling 1-0-0-1 randomly gives identical wr_addr/wr_data sequence and identical final word_count=2.
- Restart mid-word: header 03, bytes 0F 00, then restart. Expect no write. Next load 01, CE 01 0E CB writes addr0=CB0E01CE; word_count=1.
- Async reset mid-DATA: drive reset=0 between clock edges after 5 data bytes. Outputs reach reset values immediately (cpu_hold=1, done=0, word_count=0, wr_en=0) without a clock edge.
- Full depth: header 40, 256 bytes. Expect 64 writes at addr 0..63 in order, last wr_addr=63, word_count=64, done=1; a 257th byte is not accepted.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizes for the instruction memory loader and fetch side
package imem_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    WAIT_HDR,
    DATA,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - little-endian byte-to-word assembly for the imem loader
module word_assembler
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_ready_o
);

  logic [INSTR_W-1:0] shreg_q, shreg_d;
  logic [1:0]         byte_idx_q, byte_idx_d;

  // word_o already contains the byte being accepted, so the completed word is
  // available on the same edge that takes in its last byte.
  always_comb begin
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      shreg_d    = '0;
      byte_idx_d = 2'd0;
    end else if (byte_valid_i) begin
      shreg_d[8*byte_idx_q +: 8] = byte_i;
      byte_idx_d                 = byte_idx_q + 2'd1;
    end
  end

  assign word_o       = shreg_d;
  assign word_ready_o = byte_valid_i && !clear_i && (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q    <= '0;
      byte_idx_q <= 2'd0;
    end else begin
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into the instruction RAM and gates CPU reset
module imem_loader
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   restart,
  output logic                   wr_en,
  output logic [IMEM_ADDR_W-1:0] wr_addr,
  output logic [INSTR_W-1:0]     wr_data,
  output logic [IMEM_ADDR_W:0]   word_count,
  output logic                   done,
  output logic                   err,
  output logic                   cpu_hold
);

  localparam logic [7:0]           DEPTH_B = 8'(IMEM_DEPTH);
  localparam logic [IMEM_ADDR_W:0] ONE_W   = 1;

  loader_state_t            state_q, state_d;
  logic [IMEM_ADDR_W:0]     target_q, target_d;
  logic [IMEM_ADDR_W:0]     count_q, count_d;
  logic                     wr_en_q, wr_en_d;
  logic [IMEM_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]       wr_data_q, wr_data_d;

  logic                     accept;
  logic                     asm_clear;
  logic                     asm_valid;
  logic [INSTR_W-1:0]       asm_word;
  logic                     asm_ready;

  assign in_ready  = ((state_q == WAIT_HDR) || (state_q == DATA)) && !restart;
  assign accept    = in_valid && in_ready;
  assign asm_valid = accept && (state_q == DATA);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  // The word count doubles as the next write address; it is bumped on the edge
  // that launches the write so DONE and the final count arrive together.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    asm_clear = 1'b0;
    if (restart) begin
      state_d   = WAIT_HDR;
      count_d   = '0;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        WAIT_HDR: begin
          if (accept) begin
            if ((in_data == 8'd0) || (in_data > DEPTH_B)) begin
              state_d = ERR;
            end else begin
              target_d  = in_data[IMEM_ADDR_W:0];
              count_d   = '0;
              asm_clear = 1'b1;
              state_d   = DATA;
            end
          end
        end
        DATA: begin
          if (asm_ready) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[IMEM_ADDR_W-1:0];
            wr_data_d = asm_word;
            count_d   = count_q + ONE_W;
            if ((count_q + ONE_W) == target_q) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_HDR;
      target_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = count_q;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign cpu_hold   = (state_q != DONE);

endmodule
